// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: frames a PID, an optional payload stream and its CRC16
// onto the byte handshake of the low-speed serializer. Each packet is one
// tx_valid burst. The block then waits for the line to go idle before it
// accepts the next request.
module usb_tx_packetizer #(
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic       zlp,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    PID,
    PAYLOAD,
    CRC_LO,
    CRC_HI,
    DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    pid_byte;
  logic          is_data;
  logic          is_zlp;
  logic [15:0]   crc;
  logic [CW-1:0] count;
  logic          drain_first;

  // Reflected CRC16 (0xA001 shift-right form): data bits are folded in LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign busy     = (state != IDLE);
  assign in_ready = (state == PAYLOAD) && tx_ready && in_valid;

  // Byte offered to the serializer. Payload bytes come straight from the FIFO
  // head, so they stay stable until the FIFO pops them.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      PID:     tx_data = pid_byte;
      PAYLOAD: tx_data = in_data;
      CRC_LO:  tx_data = ~crc[7:0];
      CRC_HI:  tx_data = ~crc[15:8];
      default: tx_data = 8'h00;
    endcase
  end

  // Packet sequencer. tx_valid, done and err are registered in this block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pid_byte    <= 8'h00;
      is_data     <= 1'b0;
      is_zlp      <= 1'b0;
      crc         <= 16'hFFFF;
      count       <= '0;
      drain_first <= 1'b0;
      tx_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !tx_busy) begin
            pid_byte <= {~pid, pid};
            is_data  <= (pid[1:0] == 2'b11);
            is_zlp   <= zlp;
            crc      <= 16'hFFFF;
            count    <= '0;
            tx_valid <= 1'b1;
            state    <= PID;
          end
        end
        PID: begin
          if (tx_ready) begin
            if (!is_data) begin
              tx_valid    <= 1'b0;
              drain_first <= 1'b1;
              state       <= DRAIN;
            end else if (is_zlp) begin
              state <= CRC_LO;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (tx_ready) begin
            if (in_valid) begin
              crc   <= crc16_byte(crc, in_data);
              count <= count + 1'b1;
              if (in_last) begin
                state <= CRC_LO;
              end else if (count == LAST_IDX) begin
                err   <= 1'b1;
                state <= CRC_LO;
              end
            end else begin
              err         <= 1'b1;
              tx_valid    <= 1'b0;
              drain_first <= 1'b1;
              state       <= DRAIN;
            end
          end
        end
        CRC_LO: begin
          if (tx_ready) state <= CRC_HI;
        end
        CRC_HI: begin
          if (tx_ready) begin
            tx_valid    <= 1'b0;
            drain_first <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          drain_first <= 1'b0;
          if (!drain_first && !tx_busy) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: directed packets against a byte-stream model.
// A behavioural serializer and a show-ahead FIFO drive the DUT. One compare
// process checks every serializer handshake against the expected byte list.
module tb_usb_tx_packetizer;

  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pid;
  logic       zlp;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  int         exp_q[$];
  logic [7:0] fifo_d[$];
  logic       fifo_l[$];
  logic       fifo_en    = 1'b0;
  logic       force_busy = 1'b0;
  int         ready_gap  = 2;
  int         tail_len   = 3;
  int         done_cnt   = 0;
  int         err_cnt    = 0;
  int         take_cnt   = 0;

  always #5 clk = ~clk;

  usb_tx_packetizer #(.MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pid      (pid),
    .zlp      (zlp),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // CRC in the non-reflected (0x8005, shift-left) form with the result
  // bit-reversed. This equals the reflected CRC16 that goes on the wire.
  function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
    logic [15:0] n;
    logic [15:0] r;
    logic        fb;
    n = 16'hFFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = n[15] ^ b[k][i];
        n  = n << 1;
        if (fb) n = n ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = n[15 - i];
    return r;
  endfunction

  // Queue the bytes that should appear on the serializer for one packet.
  task automatic expectPacket(input logic [3:0] p, input logic [7:0] payload[$]);
    logic [15:0] c;
    exp_q.push_back(int'({~p, p}));
    if (p[1:0] == 2'b11) begin
      foreach (payload[k]) exp_q.push_back(int'(payload[k]));
      c = ~model_crc(payload);
      exp_q.push_back(int'(c[7:0]));
      exp_q.push_back(int'(c[15:8]));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic z);
    @(posedge clk); #1;
    pid   = p;
    zlp   = z;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    zlp   = 1'b0;
  endtask

  task automatic waitDone(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        checkOutput({name, "_line_idle_at_done"}, tx_busy, 0);
      end
    end
    checkOutput({name, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  // Serializer and FIFO model. It updates its outputs just after each rising edge.
  initial begin
    logic take;
    int   gap_cnt;
    int   tail;
    gap_cnt  = 0;
    tail     = 0;
    tx_ready = 1'b0;
    tx_busy  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    forever begin
      @(negedge clk);
      take = in_ready;
      @(posedge clk); #2;
      if (take && fifo_d.size() > 0) begin
        void'(fifo_d.pop_front());
        void'(fifo_l.pop_front());
      end
      in_valid = fifo_en && (fifo_d.size() > 0);
      in_data  = (fifo_d.size() > 0) ? fifo_d[0] : 8'h00;
      in_last  = (fifo_l.size() > 0) ? fifo_l[0] : 1'b0;
      if (tx_valid) begin
        tx_busy = 1'b1;
        tail    = tail_len;
        gap_cnt++;
        if (gap_cnt >= ready_gap) begin
          tx_ready = 1'b1;
          gap_cnt  = 0;
        end else begin
          tx_ready = 1'b0;
        end
      end else begin
        tx_ready = 1'b0;
        gap_cnt  = 0;
        if (tail > 0) begin
          tail--;
          tx_busy = 1'b1;
        end else begin
          tx_busy = force_busy;
        end
      end
    end
  end

  // Compare process. It checks handshaken bytes against the model, data hold
  // while not ready, the valid drop after the last byte, and done/err exclusivity.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_last_hs;
    int         e;
    prev_hold    = 1'b0;
    prev_data    = 8'h00;
    prev_last_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (prev_hold && tx_valid) checkOutput("tx_data_hold", tx_data, prev_data);
        if (prev_last_hs) checkOutput("valid_drop_after_last", tx_valid, 0);
        if (done || err) checkOutput("done_err_exclusive", done && err, 0);
        prev_last_hs = 1'b0;
        if (tx_valid && tx_ready) begin
          checkOutput("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e >= 0) checkOutput("tx_byte", tx_data, e);
            if (exp_q.size() == 0) prev_last_hs = 1'b1;
          end
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (in_ready) take_cnt++;
      end else begin
        prev_hold    = 1'b0;
        prev_last_hs = 1'b0;
      end
    end
  end

  // Directed sequence.
  initial begin
    logic [7:0] pl[$];
    logic [15:0] c;
    int base_done;
    int base_err;
    int base_take;
    logic reached;

    reset = 1'b0;
    start = 1'b0;
    pid   = 4'h0;
    zlp   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Pin the CRC model against the CRC-16/USB check value.
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    c = ~model_crc(pl);
    checkOutput("model_crc_check", c, 16'hB4C8);

    // ACK: PID-only packet.
    $display("[TB] ACK packet");
    base_done = done_cnt;
    base_err  = err_cnt;
    pl.delete();
    expectPacket(4'h2, pl);
    applyStimulus(4'h2, 1'b0);
    @(negedge clk);
    checkOutput("ack_tx_valid", tx_valid, 1);
    checkOutput("ack_tx_data", tx_data, 8'hD2);
    checkOutput("ack_busy", busy, 1);
    waitDone("ack");
    checkOutput("ack_bytes_left", exp_q.size(), 0);
    checkOutput("ack_done_count", done_cnt - base_done, 1);
    checkOutput("ack_err_count", err_cnt - base_err, 0);

    // DATA0 zero-length packet.
    $display("[TB] DATA0 zlp");
    pl.delete();
    expectPacket(4'h3, pl);
    checkOutput("zlp_model_pid", exp_q[0], 8'hC3);
    checkOutput("zlp_model_crc_lo", exp_q[1], 8'h00);
    checkOutput("zlp_model_crc_hi", exp_q[2], 8'h00);
    base_err = err_cnt;
    applyStimulus(4'h3, 1'b1);
    waitDone("zlp");
    checkOutput("zlp_bytes_left", exp_q.size(), 0);
    checkOutput("zlp_err_count", err_cnt - base_err, 0);

    // DATA1 with a three-byte payload.
    $display("[TB] DATA1 payload");
    pl.delete();
    pl.push_back(8'h01);
    pl.push_back(8'h02);
    pl.push_back(8'h03);
    foreach (pl[k]) begin
      fifo_d.push_back(pl[k]);
      fifo_l.push_back(k == 2);
    end
    fifo_en = 1'b1;
    expectPacket(4'hB, pl);
    checkOutput("data1_model_pid", exp_q[0], 8'h4B);
    base_err  = err_cnt;
    base_take = take_cnt;
    ready_gap = 3;
    applyStimulus(4'hB, 1'b0);
    waitDone("data1");
    checkOutput("data1_bytes_left", exp_q.size(), 0);
    checkOutput("data1_in_ready_pulses", take_cnt - base_take, 3);
    checkOutput("data1_err_count", err_cnt - base_err, 0);

    // Underrun: the FIFO is empty when the first payload byte is due.
    $display("[TB] underrun");
    ready_gap = 2;
    exp_q.push_back(8'hC3);
    exp_q.push_back(-1);
    base_err  = err_cnt;
    base_done = done_cnt;
    applyStimulus(4'h3, 1'b0);
    waitDone("underrun");
    checkOutput("underrun_bytes_left", exp_q.size(), 0);
    checkOutput("underrun_err_count", err_cnt - base_err, 1);
    checkOutput("underrun_done_count", done_cnt - base_done, 1);

    // Overlength: nine bytes without in_last. Eight are sent, then the CRC.
    $display("[TB] overlength");
    pl.delete();
    for (int i = 0; i < 9; i++) begin
      fifo_d.push_back(8'h10 + 8'(i));
      fifo_l.push_back(1'b0);
      if (i < MAX_LEN) pl.push_back(8'h10 + 8'(i));
    end
    expectPacket(4'h3, pl);
    base_err  = err_cnt;
    base_take = take_cnt;
    applyStimulus(4'h3, 1'b0);
    waitDone("overlen");
    checkOutput("overlen_bytes_left", exp_q.size(), 0);
    checkOutput("overlen_err_count", err_cnt - base_err, 1);
    checkOutput("overlen_in_ready_pulses", take_cnt - base_take, 8);
    checkOutput("overlen_fifo_left", fifo_d.size(), 1);
    fifo_d.delete();
    fifo_l.delete();

    // Reset during PAYLOAD aborts the packet on the next edge.
    $display("[TB] reset mid-packet");
    pl.delete();
    for (int i = 0; i < 4; i++) begin
      pl.push_back(8'hA0 + 8'(i));
      fifo_d.push_back(8'hA0 + 8'(i));
      fifo_l.push_back(i == 3);
    end
    expectPacket(4'hB, pl);
    ready_gap = 3;
    applyStimulus(4'hB, 1'b0);
    reached = 1'b0;
    for (int n = 0; n < 60 && !reached; n++) begin
      @(negedge clk);
      if (in_ready) reached = 1'b1;
    end
    checkOutput("rst_mid_reached_payload", reached, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_tx_valid", tx_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    fifo_d.delete();
    fifo_l.delete();
    repeat (8) @(posedge clk);
    #1;

    // A start while the line is still busy is ignored, not queued.
    $display("[TB] start while line busy");
    ready_gap  = 2;
    force_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    base_done = done_cnt;
    applyStimulus(4'h2, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("busy_line_start_busy", busy, 0);
    checkOutput("busy_line_start_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    force_busy = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("busy_line_no_queue_busy", busy, 0);
    checkOutput("busy_line_no_queue_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    checkOutput("busy_line_done_count", done_cnt - base_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
